// File: rtl/lrf_pkg.sv
// Shared constants and FSM encoding for the LRF frame streaming blocks.
package lrf_pkg;

    localparam int PIXELS_PER_BEAT = 16;
    localparam int IMAGE_DIM       = 512;
    localparam int DATA_WIDTH      = 8 * PIXELS_PER_BEAT;
    localparam int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int ADDR_WIDTH      = $clog2(BEATS_PER_FRAME);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_RUN   = 2'd1,
        TX_DRAIN = 2'd2
    } tx_state_t;

endpackage

// File: rtl/frame_stream_tx_if.sv
// AXI-Stream bus carrying pixel beats with SOF (tuser) and EOF (tlast) markers.
interface frame_stream_tx_if
    import lrf_pkg::*;
#(
    parameter int DATA_WIDTH = lrf_pkg::DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/frame_stream_tx_out_fifo.sv
// Two-entry registered FIFO; head entry drives the stream outputs directly so
// nothing downstream of the register depends combinationally on pop.
module axis_out_fifo2
    import lrf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic             do_pop;
    logic             do_push;

    // Pops on an empty FIFO and pushes into a full, non-popping FIFO are dropped.
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    assign dout  = head;
    assign valid = (cnt != 2'd0);
    assign count = cnt;

    // Shift-style storage: head is always the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_stream_tx.sv
// Frame playback master: reads beats from a synchronous frame buffer and
// streams them out as AXI-Stream with SOF on tuser and EOF on tlast.
module frame_stream_tx #(
    parameter int PIXELS_PER_BEAT = lrf_pkg::PIXELS_PER_BEAT,
    parameter int IMAGE_DIM       = lrf_pkg::IMAGE_DIM,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    parameter int ADDR_WIDTH      = $clog2(BEATS_PER_FRAME)
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  start,
    input  logic [7:0]            num_frames,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    frame_stream_tx_if.master     m_axis,
    output logic                  busy,
    output logic                  done
);

    import lrf_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BEATS_PER_FRAME - 1);

    tx_state_t             state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            frames_left;
    logic                  rd_vld;     // read issued last cycle, data arrives now
    logic                  tag_last;
    logic                  tag_user;
    logic [1:0]            count;
    logic                  pop;
    logic                  fifo_valid;
    logic [DATA_WIDTH+1:0] fifo_dout;

    assign pop = m_axis.tvalid & m_axis.tready;

    // Only issue when the slot is guaranteed free by the time data returns:
    // entries held + read in flight - entry leaving now must be at most one.
    assign rd_en   = (state == TX_RUN) &&
                     ((3'(count) + 3'(rd_vld)) <= (3'd1 + 3'(pop)));
    assign rd_addr = addr;

    // Playback FSM with address/frame counters and tags that ride with each read.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state       <= TX_IDLE;
            addr        <= '0;
            frames_left <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_vld      <= 1'b0;
            tag_last    <= 1'b0;
            tag_user    <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_vld   <= rd_en;
            tag_last <= (addr == LAST_ADDR);
            tag_user <= (addr == '0);
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        state       <= TX_RUN;
                        frames_left <= (num_frames == 8'd0) ? 8'd1 : num_frames;
                        addr        <= '0;
                        busy        <= 1'b1;
                    end
                end
                TX_RUN: begin
                    if (rd_en) begin
                        if (addr == LAST_ADDR) begin
                            addr        <= '0;
                            frames_left <= frames_left - 8'd1;
                            if (frames_left == 8'd1) state <= TX_DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                TX_DRAIN: begin
                    // Finish as the final beat handshakes so done lands the cycle after.
                    if (!rd_vld && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                        state <= TX_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    axis_out_fifo2 #(.WIDTH(DATA_WIDTH + 2)) u_out_fifo (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .push  (rd_vld),
        .din   ({rd_data, tag_last, tag_user}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (count)
    );

    assign m_axis.tvalid = fifo_valid;
    assign m_axis.tdata  = fifo_dout[DATA_WIDTH+1:2];
    assign m_axis.tlast  = fifo_dout[1];
    assign m_axis.tuser  = fifo_dout[0];

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx at IMAGE_DIM=8 (4 beats per frame).
module tb_frame_stream_tx;

    localparam int DW = 128;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_frames = 8'd0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          busy;
    logic          done;

    frame_stream_tx_if #(.DATA_WIDTH(DW)) bus ();

    frame_stream_tx #(.PIXELS_PER_BEAT(16), .IMAGE_DIM(8)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .start          (start),
        .num_frames     (num_frames),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .m_axis         (bus.master),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Frame buffer model: one-cycle read latency, data = addr + 0x10.
    always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr) + DW'(16'h10);

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int checks = 0;
    int failures = 0;

    // Monitor state
    int            t0 = 0;
    int            hs_cnt, first_vld, done_cnt, done_rel, gaps, stab_err, ovf_err, reads, outstanding;
    int            exp_n = 0;
    logic [DW-1:0] got_data [64];
    logic          got_last [64];
    logic          got_user [64];
    logic          prev_stall;
    logic [DW-1:0] pd;
    logic          pl, pu;

    task automatic clear_stats();
        hs_cnt = 0; first_vld = -1; done_cnt = 0; done_rel = -1; gaps = 0;
        stab_err = 0; ovf_err = 0; reads = 0; outstanding = 0; prev_stall = 1'b0;
    endtask

    always @(negedge clk) begin
        int  rel;
        logic hs;
        rel = gcyc - t0;
        hs  = bus.tvalid & bus.tready;
        if (bus.tvalid && first_vld < 0) first_vld = rel;
        if (exp_n > 0 && hs_cnt > 0 && hs_cnt < exp_n && !bus.tvalid) gaps++;
        if (prev_stall && (!bus.tvalid || bus.tdata !== pd || bus.tlast !== pl || bus.tuser !== pu))
            stab_err++;
        prev_stall = bus.tvalid & ~bus.tready;
        pd = bus.tdata; pl = bus.tlast; pu = bus.tuser;
        if (rd_en && (outstanding - int'(hs)) >= 2) ovf_err++;
        outstanding = outstanding + int'(rd_en) - int'(hs);
        if (rd_en) reads++;
        if (hs) begin
            if (hs_cnt < 64) begin
                got_data[hs_cnt] = bus.tdata;
                got_last[hs_cnt] = bus.tlast;
                got_user[hs_cnt] = bus.tuser;
            end
            hs_cnt++;
        end
        if (done) begin done_cnt++; done_rel = rel; end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // mode: 0 = tready always 1, 1 = random 30% ready, 2 = tready low for 20 cycles
    typedef struct {
        int nf;
        int mode;
        bit extra_start;
        int exp_beats;
        int exp_first;   // -1 = not checked
        int exp_done;    // -1 = not checked
    } vec_t;

    task automatic run(input vec_t v, input int idx);
        int  rel;
        bit  finished;
        finished = 1'b0;
        @(posedge clk); #1;
        clear_stats();
        exp_n      = v.exp_beats;
        t0         = gcyc;
        start      = 1'b1;
        num_frames = 8'(v.nf);
        bus.tready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            rel        = gcyc - t0;
            start      = v.extra_start && (rel == 2);
            num_frames = v.extra_start ? 8'd5 : 8'(v.nf);
            bus.tready = (v.mode == 0) ? 1'b1 :
                         (v.mode == 1) ? ($urandom_range(0, 99) < 30) : (rel > 20);
            if (v.mode == 2 && rel == 20) begin
                check($sformatf("v%0d_stall_reads", idx), DW'(reads), DW'(2));
                check($sformatf("v%0d_stall_valid", idx), DW'(bus.tvalid), DW'(1));
                check($sformatf("v%0d_stall_data", idx), bus.tdata, DW'(16'h10));
            end
            if (done_cnt > 0 && rel >= done_rel + 3) begin
                finished = 1'b1;
                break;
            end
        end
        bus.tready = 1'b1;
        check($sformatf("v%0d_timeout", idx), DW'(finished), DW'(1));
        check($sformatf("v%0d_beats", idx), DW'(hs_cnt), DW'(v.exp_beats));
        for (int i = 0; i < v.exp_beats && i < hs_cnt; i++) begin
            check($sformatf("v%0d_b%0d_data", idx, i), got_data[i], DW'(16'h10 + (i % 4)));
            check($sformatf("v%0d_b%0d_last", idx, i), DW'(got_last[i]), DW'((i % 4) == 3));
            check($sformatf("v%0d_b%0d_user", idx, i), DW'(got_user[i]), DW'((i % 4) == 0));
        end
        check($sformatf("v%0d_done_cnt", idx), DW'(done_cnt), DW'(1));
        if (v.exp_first >= 0) check($sformatf("v%0d_first_vld", idx), DW'(first_vld), DW'(v.exp_first));
        if (v.exp_done >= 0) begin
            check($sformatf("v%0d_done_cyc", idx), DW'(done_rel), DW'(v.exp_done));
            check($sformatf("v%0d_gaps", idx), DW'(gaps), DW'(0));
        end
        check($sformatf("v%0d_stability", idx), DW'(stab_err), DW'(0));
        check($sformatf("v%0d_overflow", idx), DW'(ovf_err), DW'(0));
        check($sformatf("v%0d_busy_end", idx), DW'(busy), DW'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, DW'(bus.tvalid), DW'(0));
        check({tag, "_tdata"},  bus.tdata, DW'(0));
        check({tag, "_tlast"},  DW'(bus.tlast), DW'(0));
        check({tag, "_tuser"},  DW'(bus.tuser), DW'(0));
        check({tag, "_rd_en"},  DW'(rd_en), DW'(0));
        check({tag, "_rd_addr"}, DW'(rd_addr), DW'(0));
        check({tag, "_busy"},   DW'(busy), DW'(0));
        check({tag, "_done"},   DW'(done), DW'(0));
    endtask

    vec_t vecs [5];

    initial begin
        bit reached;
        bus.tready = 1'b1;
        vecs[0] = '{nf: 1, mode: 0, extra_start: 0, exp_beats: 4,  exp_first: 3,  exp_done: 7};
        vecs[1] = '{nf: 3, mode: 0, extra_start: 0, exp_beats: 12, exp_first: 3,  exp_done: 15};
        vecs[2] = '{nf: 2, mode: 1, extra_start: 0, exp_beats: 8,  exp_first: 3,  exp_done: -1};
        vecs[3] = '{nf: 1, mode: 2, extra_start: 0, exp_beats: 4,  exp_first: 3,  exp_done: -1};
        vecs[4] = '{nf: 0, mode: 0, extra_start: 1, exp_beats: 4,  exp_first: 3,  exp_done: 7};

        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        aresetn = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        for (int i = 0; i < 5; i++) run(vecs[i], i);

        // Mid-playback reset at beat 2 of frame 1, then a clean single-frame replay.
        @(posedge clk); #1;
        clear_stats();
        t0 = gcyc;
        start = 1'b1;
        num_frames = 8'd3;
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (hs_cnt >= 6) begin reached = 1'b1; break; end
        end
        check("abort_reach_beat6", DW'(reached), DW'(1));
        check("abort_busy_before", DW'(busy), DW'(1));
        aresetn = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        aresetn = 1'b1;
        run(vecs[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_stream_tx.md
Name: frame_stream_tx

Overview:
AXI-Stream master that reads a stored frame (average or fused) from a synchronous frame-buffer read port and emits it as PIXELS_PER_BEAT-pixel beats with tlast on the final beat. It is the transmit counterpart of the LRF stream input. It replays frames to the host, or to the downstream HSSIM/fusion stage, under full m_axis backpressure. It supports back-to-back multi-frame playback without bubbles.

Parameters:
PIXELS_PER_BEAT, 16, pixels per beat
IMAGE_DIM, 512, frame width = height in pixels
DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width in bits
BEATS_PER_FRAME, IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, beats per frame (16384 at defaults)
ADDR_WIDTH, $clog2(BEATS_PER_FRAME), buffer address width

Ports:
s_axis_aclk  in  1  clock
s_axis_aresetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin playback (ignored unless idle)
num_frames  in  8  frames to play, sampled on start; 0 treated as 1
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_WIDTH  beat address within the frame
rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
m_axis_tdata  out  DATA_WIDTH  beat data
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last beat of a frame
m_axis_tuser  out  1  first beat of a frame (SOF)
busy  out  1  high from the accepted start until the final beat handshakes
done  out  1  one-cycle pulse, the cycle after the final beat handshakes

Behaviour:
- Reset (s_axis_aresetn=0 at clock edge): all outputs 0; FSM=IDLE; counters and output FIFO cleared. A mid-playback reset aborts immediately with no tlast. The in-flight read is discarded.
- FSM states:
  - IDLE: start=1 → RUN; latch frames_left=max(num_frames,1); addr=0; busy=1 next cycle.
  - RUN: issue reads. When the last address of the last frame is issued → DRAIN.
  - DRAIN: no reads. When the output FIFO is empty and no read is in flight → IDLE; done=1 for one cycle; busy=0.
- Output stage: 2-entry FIFO holding {data, last, user}.
  - m_axis_tvalid = FIFO not empty. tdata/tlast/tuser come from the head entry.
  - A handshake (tvalid & tready) pops the head.
  - Output signals stay stable while tvalid=1 and tready=0 (AXI-S rule).
- Read issue rule: rd_en = (state==RUN) & (occupancy + inflight + pop-adjusted < 2). Concretely, issue when occupancy + inflight − (handshake this cycle) ≤ 1. This guarantees no overflow.
  - With tready held high this sustains 1 beat/cycle.
  - First beat latency: start at cycle 0 → rd_en at cycle 1 → tvalid at cycle 3.
- Read-response tagging:
  - rd_data pushes into the FIFO the cycle after rd_en.
  - The tags last=(addr==BEATS_PER_FRAME-1) and user=(addr==0) are registered alongside rd_en.
- Address wrap: after BEATS_PER_FRAME-1, addr returns to 0 and frames_left decrements. There is no gap between frames: tlast of frame k is followed immediately by tuser of frame k+1.
- Simultaneous push and pop on a full FIFO is legal; occupancy stays unchanged.
- start while busy is ignored; num_frames is not resampled.
- No combinational path from m_axis_tready to m_axis_tvalid/tdata. rd_en may depend combinationally on tready.

Decomposition:
- Shared package lrf_pkg: PIXELS_PER_BEAT, IMAGE_DIM, DATA_WIDTH, BEATS_PER_FRAME, ADDR_WIDTH, and the FSM state encoding (TX_IDLE=0, TX_RUN=1, TX_DRAIN=2).
- One natural sub-module, axis_out_fifo2: a 2-deep registered FIFO with count output, instantiated for {tdata, tlast, tuser}.
- The FSM, address counter and frame counter stay in the top.

Test Plan:
- IMAGE_DIM=8 (4 beats/frame); buffer model returns data=addr+0x10. Drive num_frames=1, tready=1 → beats 0x10..0x13 on cycles 3–6; tuser on beat 0; tlast on beat 3; done pulse at cycle 7.
- num_frames=3, tready=1 → 12 consecutive beats with no tvalid gaps; tlast at beats 3, 7, 11; tuser at beats 0, 4, 8; one done.
- num_frames=2 with random tready at 30% → identical 8-beat sequence; data/last/user stable during stalls; rd_en never issued with occupancy+inflight=2; no FIFO overflow (assertion).
- Hold tready=0 for 20 cycles after start → tvalid=1 holding beat 0x10 throughout; at most 2 reads issued; release → sequence resumes intact.
- Assert reset at beat 2 of frame 1 → next cycle all outputs 0 and busy=0; a fresh start with num_frames=1 replays from addr 0 with tuser.
- start pulse during playback, and num_frames=0 → first is ignored (beat count unchanged); second plays exactly 1 frame.
